// File: rtl/mdu_stage_if.sv
// E-stage multiply/divide request/response bundle.
// The pipeline drives the op and operands; the MDU returns busy, read data and HI/LO.
interface mdu_stage_if;
    logic        E_MDU_Start;
    logic [3:0]  E_MDU_Op;
    logic [31:0] E_MDU_RS;
    logic [31:0] E_MDU_RT;
    logic        E_MDU_Busy;
    logic [31:0] E_MDU_Out;
    logic [31:0] E_MDU_HI;
    logic [31:0] E_MDU_LO;

    modport master (
        output E_MDU_Start, E_MDU_Op, E_MDU_RS, E_MDU_RT,
        input  E_MDU_Busy, E_MDU_Out, E_MDU_HI, E_MDU_LO
    );

    modport slave (
        input  E_MDU_Start, E_MDU_Op, E_MDU_RS, E_MDU_RT,
        output E_MDU_Busy, E_MDU_Out, E_MDU_HI, E_MDU_LO
    );
endinterface

// File: rtl/mdu_stage.sv
// MIPS E-stage multiply/divide unit: owns HI/LO, computes results at issue and
// commits them after a fixed busy countdown.
module mdu_stage #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic       Clk,
    input  logic       Reset_n,
    mdu_stage_if.slave mdu
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } md_op_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;   // divide by zero: suppress the commit
    } pend_t;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    pend_t         pend_q, pend_d;
    logic          busy;

    logic [31:0]   rs, rt;
    md_op_e        op;

    assign rs   = mdu.E_MDU_RS;
    assign rt   = mdu.E_MDU_RT;
    assign op   = md_op_e'(mdu.E_MDU_Op);
    assign busy = (cnt_q != '0);

    // Products
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;

    assign prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
    assign prod_u = {32'd0, rs} * {32'd0, rt};

    // Signed divide on magnitudes so MIN_INT / -1 wraps to MIN_INT without overflow.
    logic        rs_neg, rt_neg;
    logic [31:0] rs_mag, rt_mag, rt_mag_safe, rt_safe;
    logic [31:0] q_mag, r_mag;
    logic [31:0] quo_s, rem_s, quo_u, rem_u;

    assign rs_neg      = rs[31];
    assign rt_neg      = rt[31];
    assign rs_mag      = rs_neg ? (32'd0 - rs) : rs;
    assign rt_mag      = rt_neg ? (32'd0 - rt) : rt;
    assign rt_mag_safe = (rt_mag == 32'd0) ? 32'd1 : rt_mag;
    assign q_mag       = rs_mag / rt_mag_safe;
    assign r_mag       = rs_mag % rt_mag_safe;
    assign quo_s       = (rs_neg ^ rt_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem_s       = rs_neg ? (32'd0 - r_mag) : r_mag;

    assign rt_safe     = (rt == 32'd0) ? 32'd1 : rt;
    assign quo_u       = rs / rt_safe;
    assign rem_u       = rs % rt_safe;

    // Next state: countdown/commit while busy, otherwise accept a new op.
    always_comb begin
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        pend_d = pend_q;
        if (busy) begin
            if (cnt_q == CW'(1)) begin
                cnt_d = '0;
                if (!pend_q.dz) begin
                    hi_d = pend_q.hi;
                    lo_d = pend_q.lo;
                end
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end else if (mdu.E_MDU_Start) begin
            case (op)
                OP_MULT: begin
                    pend_d = '{hi: prod_s[63:32], lo: prod_s[31:0], dz: 1'b0};
                    cnt_d  = CW'(MUL_CYCLES);
                end
                OP_MULTU: begin
                    pend_d = '{hi: prod_u[63:32], lo: prod_u[31:0], dz: 1'b0};
                    cnt_d  = CW'(MUL_CYCLES);
                end
                OP_DIV: begin
                    pend_d = '{hi: rem_s, lo: quo_s, dz: (rt == 32'd0)};
                    cnt_d  = CW'(DIV_CYCLES);
                end
                OP_DIVU: begin
                    pend_d = '{hi: rem_u, lo: quo_u, dz: (rt == 32'd0)};
                    cnt_d  = CW'(DIV_CYCLES);
                end
                OP_MTHI: hi_d = rs;
                OP_MTLO: lo_d = rs;
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            pend_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            pend_q <= pend_d;
        end
    end

    // Read port sees committed HI/LO only.
    always_comb begin
        mdu.E_MDU_Out = 32'd0;
        case (op)
            OP_MFHI: mdu.E_MDU_Out = hi_q;
            OP_MFLO: mdu.E_MDU_Out = lo_q;
            default: ;
        endcase
    end

    assign mdu.E_MDU_Busy = busy;
    assign mdu.E_MDU_HI   = hi_q;
    assign mdu.E_MDU_LO   = lo_q;

endmodule

// File: tb/tb_mdu_stage.sv
// Self-checking bench for mdu_stage: directed table, corner sequences and a
// randomized run against a plain-arithmetic HI/LO model.
module tb_mdu_stage;

    localparam int MUL = 5;
    localparam int DIV = 10;

    logic Clk;
    logic Reset_n;
    int   tests;
    int   fails;
    logic [31:0] mhi, mlo;

    mdu_stage_if bus ();

    mdu_stage #(.MUL_CYCLES(MUL), .DIV_CYCLES(DIV)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .mdu     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: architectural effect of one accepted op.
    task automatic ref_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          inout logic [31:0] hi, inout logic [31:0] lo, output int lat);
        longint          a, b, q, r;
        longint unsigned ua, ub, uq, ur;
        lat = 0;
        case (op)
            4'd1: begin
                a = longint'($signed(rs)); b = longint'($signed(rt));
                q = a * b; hi = q[63:32]; lo = q[31:0]; lat = MUL;
            end
            4'd2: begin
                ua = {32'd0, rs}; ub = {32'd0, rt};
                uq = ua * ub; hi = uq[63:32]; lo = uq[31:0]; lat = MUL;
            end
            4'd3: begin
                lat = DIV;
                if (rt != 0) begin
                    a = longint'($signed(rs)); b = longint'($signed(rt));
                    q = a / b; r = a % b; lo = q[31:0]; hi = r[31:0];
                end
            end
            4'd4: begin
                lat = DIV;
                if (rt != 0) begin
                    ua = {32'd0, rs}; ub = {32'd0, rt};
                    uq = ua / ub; ur = ua % ub; lo = uq[31:0]; hi = ur[31:0];
                end
            end
            4'd5: hi = rs;
            4'd6: lo = rs;
            default: ;
        endcase
    endtask

    // Issue one op, count busy edges (optionally spraying ignored starts), then check.
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int exp_lat, input bit noisy);
        int n;
        @(negedge Clk);
        bus.E_MDU_Start = 1'b1; bus.E_MDU_Op = op; bus.E_MDU_RS = rs; bus.E_MDU_RT = rt;
        @(posedge Clk); #1;
        bus.E_MDU_Start = 1'b0; bus.E_MDU_Op = 4'd0;
        n = 0;
        while (bus.E_MDU_Busy && n < 200) begin
            @(negedge Clk);
            if (noisy) begin
                bus.E_MDU_Start = 1'($urandom_range(0, 1));
                bus.E_MDU_Op    = 4'($urandom_range(0, 9));
                bus.E_MDU_RS    = $urandom;
                bus.E_MDU_RT    = $urandom;
            end
            @(posedge Clk); #1;
            bus.E_MDU_Start = 1'b0; bus.E_MDU_Op = 4'd0;
            n++;
        end
        chk({name, " latency"}, 32'(n), 32'(exp_lat));
        chk({name, " HI"}, bus.E_MDU_HI, exp_hi);
        chk({name, " LO"}, bus.E_MDU_LO, exp_lo);
        bus.E_MDU_Op = 4'd7; #1;
        chk({name, " MFHI"}, bus.E_MDU_Out, exp_hi);
        bus.E_MDU_Op = 4'd8; #1;
        chk({name, " MFLO"}, bus.E_MDU_Out, exp_lo);
        bus.E_MDU_Op = 4'd1; #1;
        chk({name, " Out non-MF"}, bus.E_MDU_Out, 32'd0);
        bus.E_MDU_Op = 4'd0;
        mhi = exp_hi; mlo = exp_lo;
    endtask

    vec_t vt[$];

    initial begin
        logic [3:0]  rop;
        logic [31:0] rrs, rrt, ehi, elo;
        int          elat;

        tests = 0; fails = 0;
        bus.E_MDU_Start = 1'b0; bus.E_MDU_Op = 4'd0; bus.E_MDU_RS = '0; bus.E_MDU_RT = '0;
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        chk("reset Busy", 32'(bus.E_MDU_Busy), 32'd0);
        chk("reset HI", bus.E_MDU_HI, 32'd0);
        chk("reset LO", bus.E_MDU_LO, 32'd0);
        mhi = 0; mlo = 0;

        vt.push_back('{4'd1, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL});
        vt.push_back('{4'd2, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, MUL});
        vt.push_back('{4'd4, 32'd7,         32'd2,        32'd1,         32'd3,         DIV});
        vt.push_back('{4'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV});
        vt.push_back('{4'd5, 32'h11,        32'd0,        32'h11,        32'hFFFF_FFFD, 0});
        vt.push_back('{4'd6, 32'h22,        32'd0,        32'h11,        32'h22,        0});
        vt.push_back('{4'd3, 32'd5,         32'd0,        32'h11,        32'h22,        DIV});
        vt.push_back('{4'd4, 32'd9,         32'd0,        32'h11,        32'h22,        DIV});
        vt.push_back('{4'd5, 32'hABCD_0000, 32'd0,        32'hABCD_0000, 32'h22,        0});
        vt.push_back('{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, DIV});
        vt.push_back('{4'd1, 32'h0001_0000, 32'h0001_0000, 32'd1,        32'd0,         MUL});
        vt.push_back('{4'd4, 32'hFFFF_FFFF, 32'h10,       32'hF,         32'h0FFF_FFFF, DIV});
        vt.push_back('{4'd0, 32'h1234,      32'h5678,     32'hF,         32'h0FFF_FFFF, 0});
        vt.push_back('{4'd9, 32'h1234,      32'h5678,     32'hF,         32'h0FFF_FFFF, 0});
        vt.push_back('{4'd7, 32'h1234,      32'h5678,     32'hF,         32'h0FFF_FFFF, 0});

        foreach (vt[i])
            run_op($sformatf("vec%0d", i), vt[i].op, vt[i].rs, vt[i].rt,
                   vt[i].exp_hi, vt[i].exp_lo, vt[i].exp_lat, 1'b0);

        // MTLO while a MULT is in flight is dropped.
        @(negedge Clk);
        bus.E_MDU_Start = 1'b1; bus.E_MDU_Op = 4'd1; bus.E_MDU_RS = 32'd3; bus.E_MDU_RT = 32'd4;
        @(negedge Clk);
        bus.E_MDU_Op = 4'd6; bus.E_MDU_RS = 32'hDEAD_BEEF;
        @(negedge Clk);
        bus.E_MDU_Start = 1'b0; bus.E_MDU_Op = 4'd0;
        repeat (MUL) @(posedge Clk); #1;
        chk("mtlo-in-busy Busy", 32'(bus.E_MDU_Busy), 32'd0);
        chk("mtlo-in-busy LO", bus.E_MDU_LO, 32'd12);
        chk("mtlo-in-busy HI", bus.E_MDU_HI, 32'd0);

        // Start on the completion edge is ignored.
        @(negedge Clk);
        bus.E_MDU_Start = 1'b1; bus.E_MDU_Op = 4'd1; bus.E_MDU_RS = 32'd3; bus.E_MDU_RT = 32'd4;
        @(posedge Clk); #1;
        bus.E_MDU_Start = 1'b0; bus.E_MDU_Op = 4'd0;
        repeat (MUL - 1) @(posedge Clk); #1;
        chk("edge-start Busy before", 32'(bus.E_MDU_Busy), 32'd1);
        @(negedge Clk);
        bus.E_MDU_Start = 1'b1; bus.E_MDU_Op = 4'd1; bus.E_MDU_RS = 32'd5; bus.E_MDU_RT = 32'd6;
        @(posedge Clk); #1;
        bus.E_MDU_Start = 1'b0; bus.E_MDU_Op = 4'd0;
        chk("edge-start Busy after", 32'(bus.E_MDU_Busy), 32'd0);
        chk("edge-start LO", bus.E_MDU_LO, 32'd12);
        repeat (2) @(posedge Clk); #1;
        chk("edge-start Busy later", 32'(bus.E_MDU_Busy), 32'd0);
        chk("edge-start LO later", bus.E_MDU_LO, 32'd12);

        // Async reset mid-op: everything clears at once and no late commit follows.
        run_op("pre-reset MTHI", 4'd5, 32'h5555_AAAA, 32'd0, 32'h5555_AAAA, 32'd12, 0, 1'b0);
        @(negedge Clk);
        bus.E_MDU_Start = 1'b1; bus.E_MDU_Op = 4'd1; bus.E_MDU_RS = 32'd3; bus.E_MDU_RT = 32'd4;
        @(posedge Clk); #1;
        bus.E_MDU_Start = 1'b0; bus.E_MDU_Op = 4'd8;
        repeat (2) @(posedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        chk("async reset Busy", 32'(bus.E_MDU_Busy), 32'd0);
        chk("async reset HI", bus.E_MDU_HI, 32'd0);
        chk("async reset LO", bus.E_MDU_LO, 32'd0);
        chk("async reset Out", bus.E_MDU_Out, 32'd0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        for (int k = 0; k < MUL + 3; k++) begin
            @(posedge Clk); #1;
            chk("post-reset LO", bus.E_MDU_LO, 32'd0);
            chk("post-reset Busy", 32'(bus.E_MDU_Busy), 32'd0);
        end
        bus.E_MDU_Op = 4'd0;
        mhi = 0; mlo = 0;

        // Randomized ops against the model.
        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 10));
            rrs = $urandom;
            rrt = $urandom;
            case ($urandom_range(0, 5))
                0: rrt = 32'd0;
                1: begin rrs = 32'h8000_0000; rrt = 32'hFFFF_FFFF; end
                2: rrt = 32'($urandom_range(1, 9));
                default: ;
            endcase
            ehi = mhi; elo = mlo;
            ref_op(rop, rrs, rrt, ehi, elo, elat);
            run_op($sformatf("rand%0d op%0d", i, rop), rop, rrs, rrt, ehi, elo, elat,
                   1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
